// File: rtl/risc_core_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : risc_core_param
//  Purpose  : Parametrised multi-cycle RISC core (MOV/ADD/CMP/AND/MVN) with
//             s/load/w handshake, optional saturating add, selectable flag
//             update mode, carry flag and sticky illegal-opcode detect.
//  Revision : 1.0 - initial release
// ============================================================================
module risc_core_param #(
    parameter int DATA_W       = 16,
    parameter bit SAT_ADD      = 1'b0,
    parameter bit FLAGS_ON_ALU = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              C,
    output logic              w,
    output logic              illegal
);

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_GET_A  = 3'd2;
    localparam logic [2:0] S_GET_B  = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WR_IMM = 3'd5;
    localparam logic [2:0] S_WR_REG = 3'd6;

    localparam int              c_MSB  = DATA_W - 1;
    localparam logic [DATA_W-1:0] c_SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_SMIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W:0]   c_ONE  = {{DATA_W{1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_regs [0:7];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic              r_n, r_v, r_z, r_c;
    logic              r_illegal;

    // Instruction fields
    logic [2:0] w_op;
    logic [1:0] w_sub;
    logic [2:0] w_rn, w_rd, w_rm;
    logic [1:0] w_sh;
    logic [7:0] w_imm8;

    assign w_op   = r_ir[15:13];
    assign w_sub  = r_ir[12:11];
    assign w_rn   = r_ir[10:8];
    assign w_rd   = r_ir[7:5];
    assign w_sh   = r_ir[4:3];
    assign w_rm   = r_ir[2:0];
    assign w_imm8 = r_ir[7:0];

    logic w_is_movi, w_is_movr, w_is_alu, w_is_cmp, w_is_undef;

    assign w_is_movi  = (w_op == 3'b110) && (w_sub == 2'b10);
    assign w_is_movr  = (w_op == 3'b110) && (w_sub == 2'b00);
    assign w_is_alu   = (w_op == 3'b101);
    assign w_is_cmp   = w_is_alu && (w_sub == 2'b01);
    assign w_is_undef = !(w_is_movi || w_is_movr || w_is_alu);

    // Operand B source: Rm through the one-bit shifter
    logic [DATA_W-1:0] w_rm_val;
    logic [DATA_W-1:0] w_b_shift;
    logic [DATA_W-1:0] w_imm_ext;

    assign w_rm_val  = r_regs[w_rm];
    assign w_imm_ext = DATA_W'($signed(w_imm8));

    // Shifter: none / LSL#1 / LSR#1 / ASR#1
    always_comb begin
        w_b_shift = w_rm_val;
        case (w_sh)
            2'b01:   w_b_shift = {w_rm_val[DATA_W-2:0], 1'b0};
            2'b10:   w_b_shift = {1'b0, w_rm_val[DATA_W-1:1]};
            2'b11:   w_b_shift = {w_rm_val[c_MSB], w_rm_val[DATA_W-1:1]};
            default: w_b_shift = w_rm_val;
        endcase
    end

    // Arithmetic: one extra bit on both adders captures carry / no-borrow
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic              w_add_v, w_cmp_v;
    logic [DATA_W-1:0] w_add_res;
    logic [DATA_W-1:0] w_result;

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff  = {1'b0, r_a} + {1'b0, ~r_b} + c_ONE;
    assign w_add_v = (r_a[c_MSB] == r_b[c_MSB]) && (w_sum[c_MSB] != r_a[c_MSB]);
    assign w_cmp_v = (r_a[c_MSB] != r_b[c_MSB]) && (w_diff[c_MSB] != r_a[c_MSB]);

    // Saturation picks the limit matching the operands' common sign
    assign w_add_res = (SAT_ADD && w_add_v) ? (r_a[c_MSB] ? c_SMIN : c_SMAX)
                                            : w_sum[DATA_W-1:0];

    // Result selection for the instruction in EXEC
    always_comb begin
        w_result = r_b;
        if (!w_is_movr) begin
            case (w_sub)
                2'b00:   w_result = w_add_res;
                2'b10:   w_result = r_a & r_b;
                2'b11:   w_result = ~r_b;
                default: w_result = w_diff[DATA_W-1:0];
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT:   if (s) w_state_next = S_DECODE;
            S_DECODE: begin
                if (w_is_movi)
                    w_state_next = S_WR_IMM;
                else if (w_is_movr || (w_is_alu && (w_sub == 2'b11)))
                    w_state_next = S_GET_B;
                else if (w_is_alu)
                    w_state_next = S_GET_A;
                else
                    w_state_next = S_WAIT;
            end
            S_GET_A:  w_state_next = S_GET_B;
            S_GET_B:  w_state_next = S_EXEC;
            S_EXEC:   w_state_next = w_is_cmp ? S_WAIT : S_WR_REG;
            S_WR_IMM: w_state_next = S_WAIT;
            S_WR_REG: w_state_next = S_WAIT;
            default:  w_state_next = S_WAIT;
        endcase
    end

    // State, instruction register and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_WAIT;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_WAIT) && load)
                r_ir <= in;
            if ((r_state == S_DECODE) && w_is_undef)
                r_illegal <= 1'b1;
        end
    end

    // Operand latches and result register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_out <= '0;
        end else begin
            if (r_state == S_GET_A)
                r_a <= r_regs[w_rn];
            if (r_state == S_GET_B)
                r_b <= w_b_shift;
            if ((r_state == S_EXEC) && !w_is_cmp)
                r_out <= w_result;
        end
    end

    // Register file writes: immediate to Rn, ALU result to Rd
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++)
                r_regs[i] <= '0;
        end else begin
            if (r_state == S_WR_IMM)
                r_regs[w_rn] <= w_imm_ext;
            if (r_state == S_WR_REG)
                r_regs[w_rd] <= r_out;
        end
    end

    // Status flags: CMP always updates; other ALU ops only when enabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_n <= 1'b0;
            r_v <= 1'b0;
            r_z <= 1'b0;
            r_c <= 1'b0;
        end else if (r_state == S_EXEC) begin
            if (w_is_cmp) begin
                r_n <= w_diff[c_MSB];
                r_z <= (w_diff[DATA_W-1:0] == '0);
                r_v <= w_cmp_v;
                r_c <= w_diff[DATA_W];
            end else if (FLAGS_ON_ALU) begin
                r_n <= w_result[c_MSB];
                r_z <= (w_result == '0);
                r_v <= (!w_is_movr && (w_sub == 2'b00)) ? w_add_v : 1'b0;
                r_c <= (!w_is_movr && (w_sub == 2'b00)) ? w_sum[DATA_W] : 1'b0;
            end
        end
    end

    assign out     = r_out;
    assign N       = r_n;
    assign V       = r_v;
    assign Z       = r_z;
    assign C       = r_c;
    assign w       = (r_state == S_WAIT);
    assign illegal = r_illegal;

endmodule
`default_nettype wire
